add_operand_sequencer: RTL and testbench

ADD_OPERAND_SEQUENCER -- requirements
Module: add_operand_sequencer

---
 rtl/add_pkg.sv | 19 +
 rtl/add_operand_sequencer_addNbits.sv | 18 +
 rtl/add_operand_sequencer.sv | 126 ++++++++++++
 tb/tb_add_operand_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_pkg.sv
// Shared definitions for the add operand sequencer: FSM state encoding and
// the default operand width.
package add_pkg;

    localparam int ADD_N_DEFAULT = 32;

    typedef enum logic [1:0] {
        S_X   = 2'd0,
        S_Y   = 2'd1,
        S_ADD = 2'd2,
        S_OUT = 2'd3
    } state_t;

    // The sequencer can take an operand beat only while collecting x or y.
    function automatic logic accepts_operand(input state_t s);
        return (s == S_X) || (s == S_Y);
    endfunction

endpackage

// File: rtl/add_operand_sequencer_addNbits.sv
// Combinational (N+1)-bit adder with carry-in and carry-out.
module addNbits #(
    parameter int N = 32
) (
    input  logic [N:0] x,
    input  logic [N:0] y,
    input  logic       cin,
    output logic [N:0] z,
    output logic       cout
);

    logic [N+1:0] w_full;

    assign w_full = {1'b0, x} + {1'b0, y} + {{(N+1){1'b0}}, cin};
    assign z      = w_full[N:0];
    assign cout   = w_full[N+1];

endmodule

// File: rtl/add_operand_sequencer.sv
// Collects an x beat then a y/cin beat, adds them through addNbits, and holds
// the registered result until the consumer takes it. One operation in flight.
module add_operand_sequencer
    import add_pkg::*;
#(
    parameter int N     = ADD_N_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N:0]       in_data,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N:0]       out_sum,
    output logic             out_cout,
    output logic [CNT_W-1:0] op_count,
    output logic             busy
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N:0]       r_x;
    logic [N:0]       r_y;
    logic             r_cin;
    logic [N:0]       r_sum;
    logic             r_cout;
    logic [CNT_W-1:0] r_op_count;

    logic             w_ld_x;
    logic             w_ld_y;
    logic             w_cap;
    logic             w_cnt_inc;
    logic [N:0]       w_z;
    logic             w_cout;

    addNbits #(
        .N (N)
    ) u_add (
        .x    (r_x),
        .y    (r_y),
        .cin  (r_cin),
        .z    (w_z),
        .cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_X;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = accepts_operand(r_state);
        out_valid   = 1'b0;
        busy        = (r_state != S_X);
        w_ld_x      = 1'b0;
        w_ld_y      = 1'b0;
        w_cap       = 1'b0;
        w_cnt_inc   = 1'b0;
        unique case (r_state)
            S_X: begin
                if (in_valid) begin
                    w_ld_x      = 1'b1;
                    w_state_nxt = S_Y;
                end
            end
            S_Y: begin
                if (in_valid) begin
                    w_ld_y      = 1'b1;
                    w_state_nxt = S_ADD;
                end
            end
            S_ADD: begin
                w_cap       = 1'b1;
                w_state_nxt = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_cnt_inc   = 1'b1;
                    w_state_nxt = S_X;
                end
            end
            default: w_state_nxt = S_X;
        endcase
    end

    // Operand and result registers are cleared by reset so an aborted
    // operation leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x        <= '0;
            r_y        <= '0;
            r_cin      <= 1'b0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_op_count <= '0;
        end else begin
            if (w_ld_x) begin
                r_x <= in_data;
            end
            if (w_ld_y) begin
                r_y   <= in_data;
                r_cin <= in_cin;
            end
            if (w_cap) begin
                r_sum  <= w_z;
                r_cout <= w_cout;
            end
            if (w_cnt_inc) begin
                r_op_count <= r_op_count + CNT_W'(1);
            end
        end
    end

    assign out_sum  = r_sum;
    assign out_cout = r_cout;
    assign op_count = r_op_count;

endmodule

// File: tb/tb_add_operand_sequencer.sv
// Scoreboard bench for add_operand_sequencer: expected sums are queued when the
// y beat is driven and compared when the result appears.
module tb_add_operand_sequencer;

    localparam int N     = 32;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [N:0] sum;
        logic       cout;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N:0]       in_data;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [N:0]       out_sum;
    logic             out_cout;
    logic [CNT_W-1:0] op_count;
    logic             busy;

    exp_t             sb[$];
    logic [CNT_W-1:0] exp_count;
    int               n_checks;
    int               n_fail;

    add_operand_sequencer #(
        .N     (N),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .op_count  (op_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete operation: x beat, optional idle cycles, y beat, then the
    // result is checked, optionally back-pressured for 'hold' cycles, and taken.
    task automatic run_op(input logic [N:0] x, input logic [N:0] y, input logic cin,
                          input int gap, input int hold);
        exp_t         e;
        logic [N+1:0] full;
        int           waited;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL x_ready: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = x;
        in_cin   = 1'($urandom);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            in_data = {1'($urandom), $urandom};
            in_cin  = 1'($urandom);
            n_checks++;
            if (busy !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_in_s_y: busy=%b in_ready=%b out_valid=%b required 1 1 0",
                         busy, in_ready, out_valid);
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = y;
        in_cin   = cin;
        full     = {1'b0, x} + {1'b0, y} + (N+2)'(cin);
        e.sum    = full[N:0];
        e.cout   = full[N+1];
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = {1'($urandom), $urandom};
        in_cin   = 1'($urandom);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL s_add_outputs: out_valid=%b in_ready=%b busy=%b required 0 0 1",
                     out_valid, in_ready, busy);
        end
        waited = 0;
        while (out_valid !== 1'b1 && waited < 8) begin
            @(posedge clk);
            #1;
            waited++;
        end
        n_checks++;
        if (waited != 1) begin
            n_fail++;
            $display("FAIL latency: out_valid after %0d further edges, required 1", waited);
        end
        e = sb.pop_front();
        n_checks++;
        if (out_sum !== e.sum || out_cout !== e.cout) begin
            n_fail++;
            $display("FAIL result: sum=%0d cout=%b required sum=%0d cout=%b",
                     out_sum, out_cout, e.sum, e.cout);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || out_sum !== e.sum || out_cout !== e.cout ||
                in_ready !== 1'b0 || op_count !== exp_count) begin
                n_fail++;
                $display("FAIL hold: valid=%b sum=%0d cout=%b ready=%b cnt=%0d required 1 %0d %b 0 %0d",
                         out_valid, out_sum, out_cout, in_ready, op_count, e.sum, e.cout, exp_count);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        exp_count = exp_count + CNT_W'(1);
        n_checks++;
        if (op_count !== exp_count || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL handshake: cnt=%0d valid=%b ready=%b busy=%b required %0d 0 1 0",
                     op_count, out_valid, in_ready, busy, exp_count);
        end
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        exp_count = '0;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || op_count !== '0 ||
            out_sum !== '0 || out_cout !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_in_reset: valid=%b busy=%b cnt=%0d sum=%0d cout=%b required all 0",
                     tag, out_valid, busy, op_count, out_sum, out_cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_after_reset: in_ready=%b busy=%b out_valid=%b required 1 0 0",
                     tag, in_ready, busy, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        exp_count = '0;
        #3;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || op_count !== '0 ||
            out_sum !== '0 || out_cout !== 1'b0) begin
            n_fail++;
            $display("FAIL power_on_reset: valid=%b busy=%b cnt=%0d sum=%0d cout=%b required all 0",
                     out_valid, busy, op_count, out_sum, out_cout);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL release: in_ready=%b busy=%b required 1 0", in_ready, busy);
        end
    endtask

    task automatic test_basic();
        run_op(33'd2, 33'd2, 1'b0, 0, 0);
        n_checks++;
        if (op_count !== CNT_W'(1)) begin
            n_fail++;
            $display("FAIL first_count: op_count=%0d required 1", op_count);
        end
    endtask

    task automatic test_carry_cases();
        run_op(33'd255, 33'd255, 1'b1, 0, 0);
        run_op({(N+1){1'b1}}, 33'd0, 1'b1, 0, 0);
        run_op({(N+1){1'b1}}, {(N+1){1'b1}}, 1'b1, 0, 0);
        run_op({1'b1, {N{1'b0}}}, {1'b1, {N{1'b0}}}, 1'b0, 0, 0);
    endtask

    task automatic test_in_valid_idle();
        repeat (3) begin
            @(negedge clk);
            in_data = {1'($urandom), $urandom};
            n_checks++;
            if (in_ready !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_in_s_x: in_ready=%b busy=%b required 1 0", in_ready, busy);
            end
        end
        run_op(33'd1000, 33'd24, 1'b1, 3, 0);
    endtask

    task automatic test_backpressure();
        run_op(33'd123456, 33'd654321, 1'b0, 0, 5);
        run_op(33'h1_0000_0000, 33'h0_FFFF_FFFF, 1'b1, 1, 2);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 33'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pulse_reset("rst_in_s_y");
        run_op(33'd1, 33'd1, 1'b0, 0, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 33'd9;
        @(posedge clk);
        #1;
        in_data  = 33'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pending_result: out_valid=%b required 1", out_valid);
        end
        pulse_reset("rst_in_s_out");
    endtask

    task automatic test_wrap();
        pulse_reset("wrap_start");
        for (int i = 0; i < 16; i++) begin
            run_op({1'($urandom), $urandom}, {1'($urandom), $urandom}, 1'($urandom), 0, 0);
        end
        n_checks++;
        if (op_count !== '0) begin
            n_fail++;
            $display("FAIL counter_wrap: op_count=%0d required 0", op_count);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_carry_cases();
        test_in_valid_idle();
        test_backpressure();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
